// File: rtl/trace_line_sequencer_pkg.sv
// trace_line_sequencer_pkg
//   Shared types and constants for the trace line sequencer:
//   - COORD_W       : screen coordinate / sample address width
//   - YCALC_W       : signed width used for the Y mapping arithmetic
//   - DRAW_MIN_GAP  : minimum cycles the line drawer needs between line_done
//                     and the next line_start
//   - SEQ_GAP       : done->start gap the sequencer always provides (RD, LAT, ISSUE)
//   - seq_state_t   : sequencer state encoding
package trace_line_sequencer_pkg;

    localparam int COORD_W      = 10;
    localparam int YCALC_W      = 12;
    localparam int DRAW_MIN_GAP = 1;
    localparam int SEQ_GAP      = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD0   = 3'd1,
        ST_LAT0  = 3'd2,
        ST_RD    = 3'd3,
        ST_LAT   = 3'd4,
        ST_ISSUE = 3'd5,
        ST_WAITD = 3'd6,
        ST_FDONE = 3'd7
    } seq_state_t;

endpackage

// File: rtl/trace_line_sequencer_y_map.sv
// trace_line_sequencer_y_map
//   Combinational sample-to-screen-Y mapping: y = Y_BASE - sample, evaluated
//   as a signed value, clamped to [0, Y_MAX] and truncated to COORD_W bits.
// Ports:
//   sample  in   SAMPLE_W  unsigned sample value
//   y       out  COORD_W   screen y coordinate
module trace_line_sequencer_y_map
    import trace_line_sequencer_pkg::*;
#(
    parameter int SAMPLE_W = 8,
    parameter int Y_BASE   = 479,
    parameter int Y_MAX    = 479
) (
    input  logic [SAMPLE_W-1:0] sample,
    output logic [COORD_W-1:0]  y
);

    localparam logic signed [YCALC_W-1:0] Y_BASE_S = YCALC_W'(Y_BASE);
    localparam logic signed [YCALC_W-1:0] Y_MAX_S  = YCALC_W'(Y_MAX);

    logic signed [YCALC_W-1:0] diff;

    always_comb begin
        // Sample is zero-extended before the signed subtract.
        diff = Y_BASE_S - $signed(YCALC_W'(sample));
        if (diff < 0) begin
            y = '0;
        end else if (diff > Y_MAX_S) begin
            y = Y_MAX_S[COORD_W-1:0];
        end else begin
            y = diff[COORD_W-1:0];
        end
    end

endmodule

// File: rtl/trace_line_sequencer.sv
// trace_line_sequencer
//   Walks the sample RAM once per frame and issues line requests to the line
//   drawer. Default build: one line per adjacent sample pair
//   (i-1, y[i-1]) -> (i, y[i]), NUM_SAMPLES-1 lines per frame.
//   Build option TRACE_DOT_MODE_EN: one point line (x_i,y_i)->(x_i,y_i) per
//   sample, NUM_SAMPLES requests per frame.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   frame_start           1-cycle pulse, start a frame (only accepted in IDLE)
//   smp_addr / smp_data   synchronous sample RAM read port (1-cycle latency)
//   line_start            1-cycle request pulse to the drawer
//   x0,y0,x1,y1           line endpoints, stable from line_start to line_done
//   line_busy, line_done  drawer status / completion pulse
//   frame_busy            high while a frame is in progress
//   frame_done            1-cycle pulse after the final line_done
//   overrun               1-cycle pulse, frame_start seen while busy
module trace_line_sequencer
    import trace_line_sequencer_pkg::*;
#(
    parameter int NUM_SAMPLES = 640,
    parameter int SAMPLE_W    = 8,
    parameter int X_OFFSET    = 0,
    parameter int Y_BASE      = 479,
    parameter int Y_MAX       = 479
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                frame_start,
    output logic [COORD_W-1:0]  smp_addr,
    input  logic [SAMPLE_W-1:0] smp_data,
    output logic                line_start,
    output logic [COORD_W-1:0]  x0,
    output logic [COORD_W-1:0]  y0,
    output logic [COORD_W-1:0]  x1,
    output logic [COORD_W-1:0]  y1,
    input  logic                line_busy,
    input  logic                line_done,
    output logic                frame_busy,
    output logic                frame_done,
    output logic                overrun
);

    // Elaboration-time parameter checks
    if (NUM_SAMPLES < 2 || NUM_SAMPLES > 1024) begin : g_bad_num_samples
        $error("trace_line_sequencer: NUM_SAMPLES must be 2..1024");
    end
    if (X_OFFSET < 0 || X_OFFSET + NUM_SAMPLES - 1 > 1023) begin : g_bad_x_offset
        $error("trace_line_sequencer: X_OFFSET+NUM_SAMPLES-1 must fit in 10 bits");
    end
    if (SAMPLE_W < 1 || SAMPLE_W > YCALC_W - 1) begin : g_bad_sample_w
        $error("trace_line_sequencer: SAMPLE_W must be 1..11");
    end
    if (SEQ_GAP < DRAW_MIN_GAP) begin : g_bad_gap
        $error("trace_line_sequencer: drawer needs a longer done->start gap");
    end

    localparam logic [COORD_W-1:0] LAST_IDX = COORD_W'(NUM_SAMPLES - 1);
    localparam logic [COORD_W-1:0] X_OFF    = COORD_W'(X_OFFSET);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
`ifdef TRACE_DOT_MODE_EN
    localparam logic [COORD_W-1:0] FIRST_IDX = '0;
`else
    // Connected mode: sample 0 is only a start point, first line ends at 1.
    localparam logic [COORD_W-1:0] FIRST_IDX = ONE;
`endif

    seq_state_t         state_reg, state_next;
    logic [COORD_W-1:0] idx_reg, idx_next;
    logic [COORD_W-1:0] smp_addr_reg;
    logic [COORD_W-1:0] x0_reg, y0_reg, x1_reg, y1_reg;
    logic               overrun_reg;
    logic [COORD_W-1:0] y_mapped;
`ifndef TRACE_DOT_MODE_EN
    logic [COORD_W-1:0] y_prev_reg;
`endif

    trace_line_sequencer_y_map #(
        .SAMPLE_W (SAMPLE_W),
        .Y_BASE   (Y_BASE),
        .Y_MAX    (Y_MAX)
    ) u_y_map (
        .sample (smp_data),
        .y      (y_mapped)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (frame_start) state_next = ST_RD0;
            ST_RD0:   state_next = ST_LAT0;
`ifdef TRACE_DOT_MODE_EN
            ST_LAT0:  state_next = ST_ISSUE;
`else
            ST_LAT0:  state_next = ST_RD;
`endif
            ST_RD:    state_next = ST_LAT;
            ST_LAT:   state_next = ST_ISSUE;
            ST_ISSUE: if (!line_busy) state_next = ST_WAITD;
            ST_WAITD: begin
                if (line_done) begin
                    state_next = (idx_reg < LAST_IDX) ? ST_RD : ST_FDONE;
                end
            end
            ST_FDONE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        line_start = (state_reg == ST_ISSUE) && !line_busy;
        frame_busy = (state_reg != ST_IDLE);
        frame_done = (state_reg == ST_FDONE);
    end

    // Sample index: set at frame accept, advanced only after a line completes
    // and another sample remains, so it never leaves the 10-bit range.
    always_comb begin
        idx_next = idx_reg;
        if (state_reg == ST_IDLE && frame_start) begin
            idx_next = FIRST_IDX;
        end else if (state_reg == ST_WAITD && line_done && idx_reg < LAST_IDX) begin
            idx_next = idx_reg + ONE;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_reg      <= '0;
            smp_addr_reg <= '0;
            x0_reg       <= '0;
            y0_reg       <= '0;
            x1_reg       <= '0;
            y1_reg       <= '0;
            overrun_reg  <= 1'b0;
`ifndef TRACE_DOT_MODE_EN
            y_prev_reg   <= '0;
`endif
        end else begin
            idx_reg     <= idx_next;
            overrun_reg <= frame_start && (state_reg != ST_IDLE);

            // Address is presented during RD0/RD so data lands in LAT0/LAT.
            if (state_next == ST_RD0) begin
                smp_addr_reg <= '0;
            end else if (state_next == ST_RD) begin
                smp_addr_reg <= idx_next;
            end

            case (state_reg)
`ifdef TRACE_DOT_MODE_EN
                ST_LAT0, ST_LAT: begin
                    x0_reg <= X_OFF + idx_reg;
                    x1_reg <= X_OFF + idx_reg;
                    y0_reg <= y_mapped;
                    y1_reg <= y_mapped;
                end
`else
                ST_LAT0: begin
                    y_prev_reg <= y_mapped;
                end
                ST_LAT: begin
                    x0_reg <= X_OFF + idx_reg - ONE;
                    x1_reg <= X_OFF + idx_reg;
                    y0_reg <= y_prev_reg;
                    y1_reg <= y_mapped;
                end
                ST_WAITD: begin
                    // End point of this line is the start point of the next.
                    if (line_done) y_prev_reg <= y1_reg;
                end
`endif
                default: ;
            endcase
        end
    end

    assign smp_addr = smp_addr_reg;
    assign x0       = x0_reg;
    assign y0       = y0_reg;
    assign x1       = x1_reg;
    assign y1       = y1_reg;
    assign overrun  = overrun_reg;

endmodule
